freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 22 ++
 rtl/freq_meter_sync_edge.sv | 32 +++
 rtl/freq_meter.sv | 121 ++++++++++++
 tb/tb_freq_meter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency meter: FSM state encoding,
// debug view and default parameter values.
package freq_meter_pkg;

  localparam int CNT_W_DEFAULT       = 16;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef logic [1:0] fm_state_t;

  localparam fm_state_t IDLE    = 2'd0;
  localparam fm_state_t MEASURE = 2'd1;
  localparam fm_state_t TIMEOUT = 2'd2;

  // Debug view of the measurement FSM and the synchronized input.
  typedef struct packed {
    fm_state_t state;
    logic      sig_sync;
    logic      rise;
    logic      fall;
  } fm_dbg_t;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input plus a one-flop history
// used to derive single-cycle rise/fall pulses.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_p,
  output logic fall_p
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // STAGES must be 2..4; the shift below assumes at least two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q      = sync_q[STAGES-1];
  assign rise_p = q & ~prev_q;
  assign fall_p = ~q & prev_q;

endmodule

// File: rtl/freq_meter.sv
// Measures rising-to-rising period (and, with FREQ_METER_DUTY_EN, high time)
// of an asynchronous input in clk cycles; flags lock and no-edge timeout.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
`ifdef FREQ_METER_DUTY_EN
  output logic [CNT_W-1:0] high_time,
`endif
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout,
  output fm_dbg_t          dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             sig_sync;
  logic             rise_p;
  logic             fall_p;
  fm_state_t        state;
  logic [CNT_W-1:0] cnt;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (sig_in),
    .q      (sig_sync),
    .rise_p (rise_p),
    .fall_p (fall_p)
  );

`ifdef FREQ_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hcnt_hold;

  // The rise_p cycle is itself a high cycle, so the restart value is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt      <= '0;
      hcnt_hold <= '0;
    end else begin
      if (rise_p) begin
        hcnt <= CNT_ONE;
      end else if (sig_sync && (hcnt != CNT_MAX)) begin
        hcnt <= hcnt + CNT_ONE;
      end
      if (fall_p) begin
        hcnt_hold <= hcnt;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
`ifdef FREQ_METER_DUTY_EN
      high_time  <= '0;
`endif
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_p) begin
            cnt   <= CNT_ONE;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise_p) begin
            period     <= cnt;
            meas_valid <= 1'b1;
            locked     <= (cnt == period);
            cnt        <= CNT_ONE;
`ifdef FREQ_METER_DUTY_EN
            high_time  <= hcnt_hold;
`endif
          end else if (cnt == CNT_MAX) begin
            // Counter parks at its maximum; nothing wraps into a bogus period.
            state   <= TIMEOUT;
            timeout <= 1'b1;
            locked  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        TIMEOUT: begin
          if (rise_p) begin
            cnt     <= CNT_ONE;
            state   <= MEASURE;
            timeout <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg.state    = state;
  assign dbg.sig_sync = sig_sync;
  assign dbg.rise     = rise_p;
  assign dbg.fall     = fall_p;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter (CNT_W=4 so the no-edge timeout is reachable quickly).
// Build with +define+FREQ_METER_DUTY_EN to also check high_time.
module tb_freq_meter;
  import freq_meter_pkg::*;

  localparam int CNT_W = 4;
  localparam int W     = 2 * CNT_W + 1;

  // Clock / reset
  logic clk;
  logic rst_n;
  logic sig_in;
  logic [CNT_W-1:0] period;
`ifdef FREQ_METER_DUTY_EN
  logic [CNT_W-1:0] high_time;
`endif
  logic meas_valid;
  logic locked;
  logic timeout;
  fm_dbg_t dbg;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  freq_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .period     (period),
`ifdef FREQ_METER_DUTY_EN
    .high_time  (high_time),
`endif
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout),
    .dbg        (dbg)
  );

  // Scoreboard state: {high_time, locked, period}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int n_cmp = 0;
  int n_err = 0;

  int tcyc        = 0;
  int last_rise   = -1;
  int prev_period = 0;
  int last_hi     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Driver tasks: sig_in changes on falling edges, counted in tcyc.
  task automatic wait_n(input int n);
    repeat (n) begin
      @(negedge clk);
      tcyc++;
    end
  endtask

  task automatic note_rise();
    int p;
    logic [CNT_W-1:0] hi_v;
    logic [CNT_W-1:0] p_v;
    if (last_rise >= 0) begin
      p    = tcyc - last_rise;
      p_v  = CNT_W'(p);
      hi_v = CNT_W'(last_hi);
      exp_q.push_back({hi_v, (p == prev_period), p_v});
      prev_period = p;
    end
    last_rise = tcyc;
  endtask

  task automatic run_wave(input int per, input int hi, input int n);
    repeat (n) begin
      sig_in = 1'b1;
      note_rise();
      wait_n(hi);
      sig_in  = 1'b0;
      last_hi = hi;
      wait_n(per - hi);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_meas_valid"}, meas_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_state"}, dbg.state, IDLE);
`ifdef FREQ_METER_DUTY_EN
    chk({tag, "_high_time"}, high_time, 0);
`endif
  endtask

  // Monitor: pop one expectation per meas_valid pulse.
  always @(posedge clk) begin
    #1;
    if (rst_n && meas_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_meas", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("period", period, mon_e[CNT_W-1:0]);
        chk("locked", locked, mon_e[CNT_W]);
`ifdef FREQ_METER_DUTY_EN
        chk("high_time", high_time, mon_e[W-1:CNT_W+1]);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int per;
    int hi;
    int k;
    rst_n  = 1'b0;
    sig_in = 1'b0;
    wait_n(3);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    wait_n(2);

    // 50% duty, period 4: lock after the second measurement.
    run_wave(4, 2, 6);
    chk("locked_p4", locked, 1);

    // Period change 4 -> 6.
    run_wave(6, 3, 3);

    // Duty 25%, period 8.
    run_wave(8, 2, 4);

    // Random periods and duty cycles, kept below the timeout limit.
    for (int i = 0; i < 6; i++) begin
      per = $urandom_range(12, 5);
      hi  = $urandom_range(per - 1, 1);
      run_wave(per, hi, 2);
    end
    run_wave(4, 2, 3);

    // Single rise, then hold low: timeout 15 cycles after cnt=1.
    sig_in = 1'b1;
    note_rise();
    wait_n(2);
    sig_in  = 1'b0;
    last_hi = 2;
    wait_n(15);
    chk("timeout_early", timeout, 0);
    wait_n(1);
    chk("timeout_set", timeout, 1);
    chk("timeout_locked", locked, 0);
    chk("timeout_period", period, CNT_W'(prev_period));
    chk("timeout_state", dbg.state, TIMEOUT);
    last_rise = -1;
    wait_n(5);
    chk("timeout_hold", timeout, 1);

    // Resume: first rise clears timeout without a measurement.
    run_wave(4, 2, 1);
    chk("timeout_clear", timeout, 0);
    run_wave(4, 2, 3);

    // Reset pulse during the low phase of a period.
    run_wave(4, 2, 2);
    sig_in = 1'b1;
    note_rise();
    wait_n(2);
    sig_in  = 1'b0;
    last_hi = 2;
    wait_n(1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("mid_reset");
    wait_n(1);
    rst_n       = 1'b1;
    last_rise   = -1;
    prev_period = 0;
    last_hi     = 0;
    wait_n(1);
    run_wave(4, 2, 3);

    // Drain the scoreboard within a bounded number of cycles.
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      wait_n(1);
      k++;
    end
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
